// File: rtl/life_cell_rule.sv
// Single Game-of-Life style cell: neighbour population count, programmable
// birth/survive rule masks, saturating survival age and a change pulse.
module life_cell_rule #(
  parameter int                   N_NEIGHBORS   = 8,
  parameter int                   CW            = $clog2(N_NEIGHBORS + 1),
  parameter logic [N_NEIGHBORS:0] BIRTH_RESET   = (N_NEIGHBORS + 1)'(1) << 3,
  parameter logic [N_NEIGHBORS:0] SURVIVE_RESET = ((N_NEIGHBORS + 1)'(1) << 2)
                                                | ((N_NEIGHBORS + 1)'(1) << 3),
  parameter int                   AGE_WIDTH     = 4,
  parameter logic                 INIT_STATE    = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_NEIGHBORS-1:0] neighbors,
  input  logic                   step,
  input  logic                   load,
  input  logic                   load_value,
  input  logic                   rule_wr,
  input  logic [N_NEIGHBORS:0]   birth_in,
  input  logic [N_NEIGHBORS:0]   survive_in,
  output logic                   state,
  output logic [AGE_WIDTH-1:0]   age,
  output logic                   changed,
  output logic [CW-1:0]          count
);

  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  logic [N_NEIGHBORS:0]  birth_mask;
  logic [N_NEIGHBORS:0]  survive_mask;
  logic [CW-1:0]         count_c;
  logic                  birth_bit;
  logic                  survive_bit;
  logic                  next_state;
  logic                  state_d;
  logic [AGE_WIDTH-1:0]  age_d;
  logic                  changed_d;

  always_comb begin
    count_c = '0;
    for (int i = 0; i < N_NEIGHBORS; i++) begin
      count_c = count_c + CW'(neighbors[i]);
    end
  end

  assign count = count_c;

  // Select by explicit compare so a count can never address a missing mask bit.
  always_comb begin
    birth_bit   = 1'b0;
    survive_bit = 1'b0;
    for (int k = 0; k <= N_NEIGHBORS; k++) begin
      if (count_c == CW'(k)) begin
        birth_bit   = birth_mask[k];
        survive_bit = survive_mask[k];
      end
    end
  end

  assign next_state = state ? survive_bit : birth_bit;

  always_comb begin
    state_d   = state;
    age_d     = age;
    changed_d = 1'b0;
    if (load) begin
      state_d   = load_value;
      age_d     = '0;
      changed_d = (load_value != state);
    end else if (step) begin
      state_d   = next_state;
      changed_d = (next_state != state);
      if (state && next_state) begin
        age_d = (age == AGE_MAX) ? AGE_MAX : age + AGE_WIDTH'(1);
      end else begin
        age_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT_STATE;
      age     <= '0;
      changed <= 1'b0;
    end else begin
      state   <= state_d;
      age     <= age_d;
      changed <= changed_d;
    end
  end

  // Masks change only at the edge, so a step in the same cycle sees the old rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      birth_mask   <= BIRTH_RESET;
      survive_mask <= SURVIVE_RESET;
    end else if (rule_wr) begin
      birth_mask   <= birth_in;
      survive_mask <= survive_in;
    end
  end

endmodule

// File: tb/tb_life_cell_rule.sv
// Bench for life_cell_rule: vector table with scoreboard for the default
// cell, plus hand sequences for age saturation, 24-neighbour count and reset.
module tb_life_cell_rule;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic       rst_n, step, load, load_value, rule_wr;
  logic [7:0] neighbors;
  logic [8:0] birth_in, survive_in;
  logic       state, changed;
  logic [3:0] age, count;

  // AGE_WIDTH=2 instance
  logic       a_rst_n, a_step, a_load, a_lv, a_wr;
  logic [7:0] a_nb;
  logic [8:0] a_b, a_s;
  logic       a_state, a_changed;
  logic [1:0] a_age;
  logic [3:0] a_count;

  // 24-neighbour instance
  logic        w_rst_n, w_step, w_load, w_lv, w_wr;
  logic [23:0] w_nb;
  logic [24:0] w_b, w_s;
  logic        w_state, w_changed;
  logic [3:0]  w_age;
  logic [4:0]  w_count;

  life_cell_rule dut (
    .clk(clk), .rst_n(rst_n), .neighbors(neighbors), .step(step), .load(load),
    .load_value(load_value), .rule_wr(rule_wr), .birth_in(birth_in),
    .survive_in(survive_in), .state(state), .age(age), .changed(changed), .count(count)
  );

  life_cell_rule #(.AGE_WIDTH(2)) dut_a2 (
    .clk(clk), .rst_n(a_rst_n), .neighbors(a_nb), .step(a_step), .load(a_load),
    .load_value(a_lv), .rule_wr(a_wr), .birth_in(a_b), .survive_in(a_s),
    .state(a_state), .age(a_age), .changed(a_changed), .count(a_count)
  );

  life_cell_rule #(.N_NEIGHBORS(24)) dut24 (
    .clk(clk), .rst_n(w_rst_n), .neighbors(w_nb), .step(w_step), .load(w_load),
    .load_value(w_lv), .rule_wr(w_wr), .birth_in(w_b), .survive_in(w_s),
    .state(w_state), .age(w_age), .changed(w_changed), .count(w_count)
  );

  typedef struct {
    logic       ld, lv, st, wr;
    logic [8:0] b, s;
    logic [7:0] nb;
    logic [3:0] ecnt;
    logic       es;
    logic [3:0] eage;
    logic       ech;
  } vec_t;

  typedef struct {
    int         idx;
    logic       es;
    logic [3:0] eage;
    logic       ech;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic lv, input logic st, input logic wr,
                              input logic [8:0] b, input logic [8:0] s, input logic [7:0] nb,
                              input logic [3:0] ecnt, input logic es, input logic [3:0] eage,
                              input logic ech);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.wr = wr; v.b = b; v.s = s; v.nb = nb;
    v.ecnt = ecnt; v.es = es; v.eage = eage; v.ech = ech;
    return v;
  endfunction

  // drive one vector, check the combinational count, then score the registered result
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    load = v.ld; load_value = v.lv; step = v.st; rule_wr = v.wr;
    birth_in = v.b; survive_in = v.s; neighbors = v.nb;
    #1;
    chk($sformatf("count[%0d]", idx), 32'(count), 32'(v.ecnt));
    e.idx = idx; e.es = v.es; e.eage = v.eage; e.ech = v.ech;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk($sformatf("sb_empty[%0d]", idx), 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("state[%0d]", e.idx), 32'(state), 32'(e.es));
      chk($sformatf("age[%0d]", e.idx), 32'(age), 32'(e.eage));
      chk($sformatf("changed[%0d]", e.idx), 32'(changed), 32'(e.ech));
    end
  endtask

  task automatic idle_main();
    load = 1'b0; load_value = 1'b0; step = 1'b0; rule_wr = 1'b0;
    birth_in = '0; survive_in = '0; neighbors = '0;
  endtask

  initial begin
    logic [1:0] age_seq [5];
    age_seq[0] = 2'd1; age_seq[1] = 2'd2; age_seq[2] = 2'd3;
    age_seq[3] = 2'd3; age_seq[4] = 2'd3;

    //          ld lv st wr  birth   survive  nb     cnt  st age ch
    vt.push_back(mk(0, 0, 1, 0, 9'h000, 9'h000, 8'h07, 4'd3, 1, 4'd0, 1)); // birth B3
    vt.push_back(mk(0, 0, 1, 0, 9'h000, 9'h000, 8'h03, 4'd2, 1, 4'd1, 0)); // survive S2
    vt.push_back(mk(0, 0, 1, 0, 9'h000, 9'h000, 8'hF0, 4'd4, 0, 4'd0, 1)); // death
    vt.push_back(mk(0, 0, 0, 0, 9'h000, 9'h000, 8'h00, 4'd0, 0, 4'd0, 0));
    vt.push_back(mk(0, 0, 0, 0, 9'h000, 9'h000, 8'h00, 4'd0, 0, 4'd0, 0));
    vt.push_back(mk(0, 0, 0, 0, 9'h000, 9'h000, 8'h00, 4'd0, 0, 4'd0, 0));
    vt.push_back(mk(1, 1, 1, 0, 9'h000, 9'h000, 8'h00, 4'd0, 1, 4'd0, 1)); // load beats step
    vt.push_back(mk(0, 0, 1, 0, 9'h000, 9'h000, 8'h70, 4'd3, 1, 4'd1, 0));
    vt.push_back(mk(0, 0, 0, 0, 9'h000, 9'h000, 8'hFF, 4'd8, 1, 4'd1, 0)); // hold
    vt.push_back(mk(1, 1, 0, 0, 9'h000, 9'h000, 8'h00, 4'd0, 1, 4'd0, 0)); // load same value
    vt.push_back(mk(0, 0, 1, 0, 9'h000, 9'h000, 8'h05, 4'd2, 1, 4'd1, 0));
    vt.push_back(mk(0, 0, 1, 0, 9'h000, 9'h000, 8'h0E, 4'd3, 1, 4'd2, 0));
    vt.push_back(mk(1, 0, 0, 0, 9'h000, 9'h000, 8'h0E, 4'd3, 0, 4'd0, 1));
    vt.push_back(mk(0, 0, 1, 1, 9'h004, 9'h00C, 8'h05, 4'd2, 0, 4'd0, 0)); // old B3 used
    vt.push_back(mk(0, 0, 1, 0, 9'h000, 9'h000, 8'h05, 4'd2, 1, 4'd0, 1)); // new B2
    vt.push_back(mk(0, 0, 1, 1, 9'h004, 9'h000, 8'h05, 4'd2, 1, 4'd1, 0)); // old S23 used
    vt.push_back(mk(0, 0, 1, 0, 9'h000, 9'h000, 8'h05, 4'd2, 0, 4'd0, 1)); // new S none
    vt.push_back(mk(0, 0, 1, 0, 9'h000, 9'h000, 8'hFF, 4'd8, 0, 4'd0, 0));
    vt.push_back(mk(0, 0, 0, 1, 9'h100, 9'h000, 8'hFF, 4'd8, 0, 4'd0, 0)); // B8 only
    vt.push_back(mk(0, 0, 1, 0, 9'h000, 9'h000, 8'hFF, 4'd8, 1, 4'd0, 1)); // top mask bit
    vt.push_back(mk(0, 0, 1, 0, 9'h000, 9'h000, 8'h00, 4'd0, 0, 4'd0, 1));
    vt.push_back(mk(0, 0, 1, 0, 9'h000, 9'h000, 8'h00, 4'd0, 0, 4'd0, 0)); // dead->dead
    vt.push_back(mk(1, 1, 1, 1, 9'h008, 9'h00C, 8'h00, 4'd0, 1, 4'd0, 1)); // all three
    vt.push_back(mk(0, 0, 1, 0, 9'h000, 9'h000, 8'h03, 4'd2, 1, 4'd1, 0));

    idle_main();
    a_step = 0; a_load = 0; a_lv = 0; a_wr = 0; a_nb = '0; a_b = '0; a_s = '0;
    w_step = 0; w_load = 0; w_lv = 0; w_wr = 0; w_nb = '0; w_b = '0; w_s = '0;
    rst_n = 1'b1; a_rst_n = 1'b1; w_rst_n = 1'b1;
    #2;
    rst_n = 1'b0; a_rst_n = 1'b0; w_rst_n = 1'b0;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_age", 32'(age), 32'd0);
    chk("reset_changed", 32'(changed), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; a_rst_n = 1'b1; w_rst_n = 1'b1;

    foreach (vt[i]) apply(i, vt[i]);

    // mid-run reset with a pending step and rule write that must be discarded
    step = 1'b1; neighbors = 8'h07; rule_wr = 1'b1; birth_in = '0; survive_in = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_age", 32'(age), 32'd0);
    chk("midrst_changed", 32'(changed), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_held", 32'(state), 32'd0);
    idle_main();
    @(negedge clk);
    rst_n = 1'b1;
    apply(100, mk(0, 0, 1, 0, 9'h000, 9'h000, 8'h07, 4'd3, 1, 4'd0, 1)); // B3 restored
    apply(101, mk(0, 0, 1, 0, 9'h000, 9'h000, 8'h03, 4'd2, 1, 4'd1, 0)); // S23 restored
    idle_main();

    // AGE_WIDTH=2 saturation
    a_load = 1'b1; a_lv = 1'b1;
    @(posedge clk); #1;
    a_load = 1'b0; a_step = 1'b1; a_nb = 8'h03;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("a2_age[%0d]", i), 32'(a_age), 32'(age_seq[i]));
      chk($sformatf("a2_state[%0d]", i), 32'(a_state), 32'd1);
    end
    a_step = 1'b0;

    // 24 neighbours
    w_nb = '1;
    #1;
    chk("w_count24", 32'(w_count), 32'd24);
    w_step = 1'b1;
    @(posedge clk); #1;
    chk("w_no_birth24", 32'(w_state), 32'd0);
    w_step = 1'b0; w_wr = 1'b1; w_b = 25'h1000000; w_s = 25'h1000000;
    @(posedge clk); #1;
    w_wr = 1'b0; w_step = 1'b1;
    @(posedge clk); #1;
    chk("w_birth24", 32'(w_state), 32'd1);
    chk("w_changed24", 32'(w_changed), 32'd1);
    w_step = 1'b0;
    #2;
    w_rst_n = 1'b0;
    #1;
    chk("w_rst_state", 32'(w_state), 32'd0);
    chk("w_rst_age", 32'(w_age), 32'd0);
    @(negedge clk);
    w_rst_n = 1'b1;
    w_step = 1'b1;
    @(posedge clk); #1;
    chk("w_mask_restored", 32'(w_state), 32'd0);
    w_step = 1'b0;

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_cell_rule.md
LIFE_CELL_RULE -- requirements
Module: life_cell_rule

Interface
REQ-001 Parameter N_NEIGHBORS, default 8; number of neighbour inputs, legal range 1..24.
REQ-002 Parameter CW, default $clog2(N_NEIGHBORS+1); width of the neighbour-count bus.
REQ-003 Parameter BIRTH_RESET, default (N_NEIGHBORS+1)'b1 << 3; birth mask after reset, where bit k set means a dead cell with k live neighbours becomes alive.
REQ-004 Parameter SURVIVE_RESET, default ((N_NEIGHBORS+1)'b1 << 2) | ((N_NEIGHBORS+1)'b1 << 3); survive mask after reset, where bit k set means a live cell with k live neighbours stays alive.
REQ-005 Parameter AGE_WIDTH, default 4; width of the age counter.
REQ-006 Parameter INIT_STATE, default 0; value of state after reset.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 neighbors  input  N_NEIGHBORS  current states of the neighbour cells, 1 = alive.
REQ-010 step  input  1  advance one generation this cycle.
REQ-011 load  input  1  overwrite the cell state with load_value.
REQ-012 load_value  input  1  state to load.
REQ-013 rule_wr  input  1  write new rule masks.
REQ-014 birth_in  input  N_NEIGHBORS+1  new birth mask.
REQ-015 survive_in  input  N_NEIGHBORS+1  new survive mask.
REQ-016 state  output  1  registered cell state.
REQ-017 age  output  AGE_WIDTH  consecutive surviving generations, saturating.
REQ-018 changed  output  1  registered one-cycle pulse, asserted when the previous update altered state.
REQ-019 count  output  CW  combinational population count of neighbors.

Function
REQ-020 count SHALL equal the number of 1 bits in neighbors, 0..N_NEIGHBORS, with no overflow at CW width.
REQ-021 next_state SHALL be survive_mask[count] when state=1, and birth_mask[count] when state=0.
REQ-022 Per-edge priority SHALL be: load, then step, then hold.
REQ-023 When load=1, state SHALL take load_value, age SHALL clear to 0, and step SHALL be ignored that cycle.
REQ-024 When step=1 and load=0, state SHALL take next_state.
REQ-025 On a step where the cell survives (1->1), age SHALL increment by 1 and saturate at 2^AGE_WIDTH-1.
REQ-026 On a step producing a birth (0->1), a death (1->0), or a dead-to-dead transition, age SHALL clear to 0.
REQ-027 When neither load nor step is asserted, state and age SHALL hold.
REQ-028 changed SHALL be 1 for exactly one cycle after any load or step edge where state differs from its prior value, and SHALL be 0 otherwise, including during idle cycles.
REQ-029 rule_wr=1 SHALL update both masks at the clock edge.
REQ-030 A step in the same cycle as rule_wr SHALL use the old masks; the new masks SHALL take effect from the next cycle.
REQ-031 rule_wr SHALL be independent of load and step, and all three MAY be asserted together.
REQ-032 Mask bits above index N_NEIGHBORS do not exist; no count value SHALL index out of range.
REQ-033 Latency SHALL be one cycle from step, load or rule_wr to the updated registered output.

Reset
REQ-034 While rst_n=0, state SHALL be INIT_STATE, age SHALL be 0, changed SHALL be 0, birth_mask SHALL be BIRTH_RESET, and survive_mask SHALL be SURVIVE_RESET, with outputs updating immediately and independent of clk.
REQ-035 Reset asserted mid-operation SHALL discard any pending step, load or rule_wr in that cycle.
REQ-036 The first rising edge after rst_n deasserts SHALL be processed normally.

Verification
REQ-037 Default B3/S23, state=0, neighbors=8'b0000_0111, step -> state=1, age=0, changed=1 for one cycle; next step with neighbors=8'b0000_0011 -> state=1, age=1, changed=0.
REQ-038 state=1, neighbors=8'b1111_0000 (count 4), step -> state=0, age=0, changed=1; then 3 idle cycles -> state=0, changed=0.
REQ-039 AGE_WIDTH=2, live cell with count 2, step repeated 5 times -> age sequence 1,2,3,3,3, state stays 1.
REQ-040 load=1, load_value=1, step=1, neighbors=0 in the same cycle -> state=1, age=0, changed=1, and the step is ignored.
REQ-041 rule_wr with birth_in=9'b0_0000_0100 together with a step at count 2 on a dead cell -> state remains 0; a step at count 2 on the next cycle -> state=1.
REQ-042 N_NEIGHBORS=24 with all neighbours alive -> count=24; rst_n pulsed low mid-run -> state=INIT_STATE, age=0, and masks restored to their reset values asynchronously.
